// File: rtl/jtframe_layer_colmix.sv
// Layer priority mixer: picks the top opaque layer, fetches its colour from a byte-wide palette RAM.
// Define JTFRAME_COLMIX_PALGATE_EN to defer CPU palette writes made during active video until blanking.
module jtframe_layer_colmix #(
    parameter  int LAYERS = 2,
    parameter  int PXLW   = 11,
    parameter  int PALW   = 11,
    parameter  int COLW   = 4,
    localparam int BSW    = (COLW == 8) ? 2 : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pxl_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    input  logic                   video_enb,
    input  logic [LAYERS*PXLW-1:0] layer_pxl,
    input  logic                   pal_bank,
    input  logic                   pal_cs,
    input  logic                   wr_n,
    input  logic [PALW+BSW-1:0]    cpu_addr,
    input  logic [7:0]             cpu_dout,
    output logic [7:0]             pal_dout,
    output logic [COLW-1:0]        red,
    output logic [COLW-1:0]        green,
    output logic [COLW-1:0]        blue,
    output logic                   pal_wr_pend
);

    localparam int BYTES    = (COLW == 8) ? 3 : 2;
    localparam int AW       = BSW + 1 + PALW;
    localparam bit HAS_HOLE = BYTES < (1 << BSW);

    typedef enum logic [1:0] {IDLE, RD0, RD1, RD2} state_t;

    state_t          st, st_nxt;
    logic [1:0]      rd_idx;
    logic [PALW-1:0] sel_entry;
    logic            found;
    logic [PALW-1:0] entry_l;
    logic            bank_l;
    logic [AW-1:0]   fetch_addr;
    logic [7:0]      fetch_q;
    logic            fetch_vld;
    logic [1:0]      fetch_sel;
    logic [COLW-1:0] r_stg, g_stg, b_stg;
    logic            blank;

    logic [7:0] mem [0:(1<<AW)-1];

    logic [PALW-1:0] cpu_entry;
    logic [BSW-1:0]  cpu_sel;
    logic [AW-1:0]   cpu_ram_addr;
    logic            sel_ok;
    logic            wr_req;
    logic            commit;
    logic [AW-1:0]   commit_addr;
    logic [7:0]      commit_data;

    always_comb begin
        sel_entry = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < LAYERS; k++) begin
            if (!found && layer_pxl[k*PXLW +: 4] != 4'hF) begin
                sel_entry = PALW'(layer_pxl[k*PXLW +: PXLW]);
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st      <= IDLE;
            entry_l <= '0;
            bank_l  <= 1'b0;
        end else begin
            st <= st_nxt;
            if (pxl_cen) begin
                entry_l <= sel_entry;
                bank_l  <= pal_bank;
            end
        end
    end

    always_comb begin
        st_nxt = st;
        rd_idx = 2'd0;
        case (st)
            IDLE: st_nxt = IDLE;
            RD0: begin
                rd_idx = 2'd0;
                st_nxt = RD1;
            end
            RD1: begin
                rd_idx = 2'd1;
                st_nxt = (BYTES == 3) ? RD2 : IDLE;
            end
            RD2: begin
                rd_idx = 2'd2;
                st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
        endcase
        // A new pixel always restarts the fetch, even mid-sequence
        if (pxl_cen) st_nxt = RD0;
    end

    assign fetch_addr = {BSW'(rd_idx), bank_l, entry_l};

    always_ff @(posedge clk) begin
        fetch_q <= mem[fetch_addr];
        if (!rst_n) begin
            fetch_vld <= 1'b0;
            fetch_sel <= 2'd0;
        end else begin
            fetch_vld <= st != IDLE;
            fetch_sel <= rd_idx;
        end
    end

    generate
        if (COLW == 8) begin : g_col8
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_stg <= '0;
                    g_stg <= '0;
                    b_stg <= '0;
                end else if (fetch_vld) begin
                    case (fetch_sel)
                        2'd0:    r_stg <= fetch_q;
                        2'd1:    g_stg <= fetch_q;
                        2'd2:    b_stg <= fetch_q;
                        default: ;
                    endcase
                end
            end
        end else begin : g_col4
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_stg <= '0;
                    g_stg <= '0;
                    b_stg <= '0;
                end else if (fetch_vld) begin
                    case (fetch_sel)
                        2'd0: r_stg <= fetch_q[3:0];
                        2'd1: begin
                            g_stg <= fetch_q[7:4];
                            b_stg <= fetch_q[3:0];
                        end
                        default: ;
                    endcase
                end
            end
        end
    endgenerate

    assign blank = !LHBL || !LVBL || video_enb;

    always_ff @(posedge clk) begin
        if (!rst_n || blank) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (pxl_cen) begin
            red   <= r_stg;
            green <= g_stg;
            blue  <= b_stg;
        end
    end

    assign cpu_entry    = cpu_addr[PALW+BSW-1:BSW];
    assign cpu_sel      = cpu_addr[BSW-1:0];
    assign cpu_ram_addr = {cpu_sel, pal_bank, cpu_entry};
    assign sel_ok       = !HAS_HOLE || (cpu_sel != '1);
    assign wr_req       = pal_cs && !wr_n && sel_ok;

`ifdef JTFRAME_COLMIX_PALGATE_EN
    logic          pend;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;
    logic          active;

    assign active = LHBL && LVBL && !video_enb;

    always_comb begin
        commit      = 1'b0;
        commit_addr = cpu_ram_addr;
        commit_data = cpu_dout;
        if (!active) begin
            if (pend) begin
                commit      = 1'b1;
                commit_addr = buf_addr;
                commit_data = buf_data;
            end else if (wr_req) begin
                commit = 1'b1;
            end
        end
    end

    // A write landing while the buffer drains in blanking is queued behind it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend     <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (wr_req && (active || pend)) begin
            pend     <= 1'b1;
            buf_addr <= cpu_ram_addr;
            buf_data <= cpu_dout;
        end else if (!active) begin
            pend <= 1'b0;
        end
    end

    assign pal_wr_pend = pend;
`else
    assign commit      = wr_req;
    assign commit_addr = cpu_ram_addr;
    assign commit_data = cpu_dout;
    assign pal_wr_pend = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n && commit) mem[commit_addr] <= commit_data;
        pal_dout <= sel_ok ? mem[cpu_ram_addr] : 8'h00;
    end

endmodule

// File: tb/tb_jtframe_layer_colmix.sv
// Self-checking bench for jtframe_layer_colmix: vector table, random pixels against a palette model.
module tb_jtframe_layer_colmix;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pxl_cen = 1'b0;
    logic        LHBL = 1'b1;
    logic        LVBL = 1'b1;
    logic        video_enb = 1'b0;
    logic [21:0] layer_pxl = '0;
    logic        pal_bank = 1'b0;
    logic        pal_cs = 1'b0;
    logic        wr_n = 1'b1;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_dout = '0;
    logic [7:0]  pal_dout;
    logic [3:0]  red, green, blue;
    logic        pal_wr_pend;

    logic [15:0] layer_pxl8 = '0;
    logic        pal_cs8 = 1'b0;
    logic [9:0]  cpu_addr8 = '0;
    logic [7:0]  pal_dout8, red8, green8, blue8;
    logic        pal_wr_pend8;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [0:8191];

    jtframe_layer_colmix #(.LAYERS(2), .PXLW(11), .PALW(11), .COLW(4)) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .video_enb(video_enb), .layer_pxl(layer_pxl), .pal_bank(pal_bank),
        .pal_cs(pal_cs), .wr_n(wr_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .pal_dout(pal_dout), .red(red), .green(green), .blue(blue),
        .pal_wr_pend(pal_wr_pend)
    );

    jtframe_layer_colmix #(.LAYERS(2), .PXLW(8), .PALW(8), .COLW(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .video_enb(video_enb), .layer_pxl(layer_pxl8), .pal_bank(pal_bank),
        .pal_cs(pal_cs8), .wr_n(wr_n), .cpu_addr(cpu_addr8), .cpu_dout(cpu_dout),
        .pal_dout(pal_dout8), .red(red8), .green(green8), .blue(blue8),
        .pal_wr_pend(pal_wr_pend8)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not end, got timeout, required $finish");
        $fatal(1);
    end

    typedef struct {
        logic [10:0] l0;
        logic [10:0] l1;
        logic        bank;
        logic [11:0] rgb;
    } vec_t;

    function automatic int ram_idx(input int sel, input int bank, input int entry);
        return sel * 4096 + bank * 2048 + entry;
    endfunction

    // Highest-priority opaque layer wins; all transparent means background entry 0
    function automatic logic [10:0] pick_entry(input logic [10:0] l0, input logic [10:0] l1);
        logic [10:0] px [2];
        px[0] = l0;
        px[1] = l1;
        for (int k = 0; k < 2; k++)
            if (px[k][3:0] != 4'hF) return px[k];
        return 11'd0;
    endfunction

    function automatic logic [11:0] colour(input logic [10:0] entry, input logic bank);
        logic [7:0] b0, b1;
        b0 = ref_mem[ram_idx(0, int'(bank), int'(entry))];
        b1 = ref_mem[ram_idx(1, int'(bank), int'(entry))];
        return {b0[3:0], b1[7:4], b1[3:0]};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse();
        pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
    endtask

    task automatic show(input logic [10:0] l0, input logic [10:0] l1, input logic bank);
        layer_pxl = {l1, l0};
        pal_bank  = bank;
        pulse();
        tick(5);
        pulse();
    endtask

    task automatic strobe(input logic [10:0] entry, input logic sel, input logic bank, input logic [7:0] data);
        cpu_addr = {entry, sel};
        pal_bank = bank;
        cpu_dout = data;
        pal_cs   = 1'b1;
        wr_n     = 1'b0;
        tick();
        pal_cs   = 1'b0;
        wr_n     = 1'b1;
    endtask

    task automatic cpu_wr(input logic [10:0] entry, input logic sel, input logic bank, input logic [7:0] data);
        strobe(entry, sel, bank, data);
        ref_mem[ram_idx(int'(sel), int'(bank), int'(entry))] = data;
    endtask

    task automatic cpu_wr8(input logic [7:0] entry, input logic [1:0] sel, input logic [7:0] data);
        cpu_addr8 = {entry, sel};
        pal_bank  = 1'b1;
        cpu_dout  = data;
        pal_cs8   = 1'b1;
        wr_n      = 1'b0;
        tick();
        pal_cs8   = 1'b0;
        wr_n      = 1'b1;
    endtask

    initial begin
        vec_t        vecs[7];
        logic [10:0] pool [8];
        logic [11:0] expq [$];
        logic [10:0] l0, l1;
        logic        bk;
        logic [11:0] e;

        vecs[0] = '{11'h00F, 11'h123, 1'b0, 12'h357};
        vecs[1] = '{11'h042, 11'h123, 1'b0, 12'h9AB};
        vecs[2] = '{11'h7FF, 11'h7FF, 1'b0, 12'h123};
        vecs[3] = '{11'h10F, 11'h123, 1'b0, 12'h357};
        vecs[4] = '{11'h123, 11'h042, 1'b1, 12'hCDE};
        vecs[5] = '{11'h7F0, 11'h7FF, 1'b0, 12'h60F};
        vecs[6] = '{11'h7FF, 11'h00F, 1'b1, 12'h444};

        tick(2);
        check("reset_rgb", {red, green, blue}, 12'h000);
        check("reset_pend", pal_wr_pend, 1'b0);
        rst_n = 1'b1;

        LVBL = 1'b0;
        cpu_wr(11'h123, 1'b0, 1'b0, 8'h03); cpu_wr(11'h123, 1'b1, 1'b0, 8'h57);
        cpu_wr(11'h042, 1'b0, 1'b0, 8'h09); cpu_wr(11'h042, 1'b1, 1'b0, 8'hAB);
        cpu_wr(11'h000, 1'b0, 1'b0, 8'h01); cpu_wr(11'h000, 1'b1, 1'b0, 8'h23);
        cpu_wr(11'h123, 1'b0, 1'b1, 8'h0C); cpu_wr(11'h123, 1'b1, 1'b1, 8'hDE);
        cpu_wr(11'h7F0, 1'b0, 1'b0, 8'hA6); cpu_wr(11'h7F0, 1'b1, 1'b0, 8'h0F);
        cpu_wr(11'h000, 1'b0, 1'b1, 8'h04); cpu_wr(11'h000, 1'b1, 1'b1, 8'h44);
        tick(2);
        check("blank_during_init", {red, green, blue}, 12'h000);
        LVBL = 1'b1;

        for (int i = 0; i < 7; i++) begin
            show(vecs[i].l0, vecs[i].l1, vecs[i].bank);
            check($sformatf("vec%0d_rgb", i), {red, green, blue}, vecs[i].rgb);
            tick(5);
        end

        show(11'h00F, 11'h123, 1'b0);
        check("preblank_rgb", {red, green, blue}, 12'h357);
        LHBL = 1'b0;
        tick();
        check("lhbl_black", {red, green, blue}, 12'h000);
        tick(4);
        pulse();
        check("lhbl_black_on_cen", {red, green, blue}, 12'h000);
        tick(5);
        LHBL = 1'b1;
        pulse();
        tick(5);
        pulse();
        check("unblank_second_cen", {red, green, blue}, 12'h357);
        video_enb = 1'b1;
        tick();
        check("video_enb_black", {red, green, blue}, 12'h000);
        video_enb = 1'b0;
        LVBL = 1'b0;
        tick();
        check("lvbl_black", {red, green, blue}, 12'h000);
        LVBL = 1'b1;
        tick(5);

        // Second pixel one clock after the first: fetch restarts on the new entry
        layer_pxl = {11'h7FF, 11'h7F0};
        pal_bank  = 1'b0;
        pxl_cen   = 1'b1;
        tick();
        layer_pxl = {11'h7FF, 11'h123};
        tick();
        pxl_cen = 1'b0;
        tick(5);
        pulse();
        check("restart_rgb", {red, green, blue}, 12'h357);
        tick(5);

        LVBL = 1'b0;
        cpu_wr(11'h300, 1'b0, 1'b0, 8'h05);
        cpu_addr = {11'h301, 1'b0};
        cpu_dout = 8'h11;
        pal_cs   = 1'b1;
        wr_n     = 1'b0;
        tick();
        cpu_addr = {11'h302, 1'b0};
        cpu_dout = 8'h22;
        tick();
        pal_cs = 1'b0;
        wr_n   = 1'b1;
        ref_mem[ram_idx(0, 0, 'h301)] = 8'h11;
        ref_mem[ram_idx(0, 0, 'h302)] = 8'h22;
        cpu_addr = {11'h301, 1'b0};
        tick();
        check("burst_wr_a", pal_dout, 8'h11);
        cpu_addr = {11'h302, 1'b0};
        tick();
        check("burst_wr_b", pal_dout, 8'h22);
        LVBL = 1'b1;
        tick();

        strobe(11'h300, 1'b0, 1'b0, 8'h77);
        strobe(11'h300, 1'b0, 1'b0, 8'hAB);
`ifdef JTFRAME_COLMIX_PALGATE_EN
        check("gate_pend_set", pal_wr_pend, 1'b1);
        tick();
        check("gate_ram_unchanged", pal_dout, 8'h05);
        tick(3);
        check("gate_still_pending", pal_wr_pend, 1'b1);
        LVBL = 1'b0;
        tick();
        check("gate_pend_clear", pal_wr_pend, 1'b0);
        tick();
        check("gate_committed", pal_dout, 8'hAB);
        LVBL = 1'b1;
`else
        check("direct_pend_zero", pal_wr_pend, 1'b0);
        tick();
        check("direct_committed", pal_dout, 8'hAB);
`endif
        ref_mem[ram_idx(0, 0, 'h300)] = 8'hAB;
        tick(2);

        LVBL = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pool[i] = 11'($urandom_range(1, 2047));
            if (pool[i][3:0] == 4'hF) pool[i][0] = 1'b0;
            for (int b = 0; b < 2; b++) begin
                cpu_wr(pool[i], 1'b0, b[0], 8'($urandom));
                cpu_wr(pool[i], 1'b1, b[0], 8'($urandom));
            end
        end
        for (int i = 0; i < 8; i++) begin
            logic [10:0] en;
            logic        s, b;
            en = pool[$urandom_range(0, 7)];
            s  = 1'($urandom);
            b  = 1'($urandom);
            cpu_addr = {en, s};
            pal_bank = b;
            tick();
            check($sformatf("readback%0d", i), pal_dout, ref_mem[ram_idx(int'(s), int'(b), int'(en))]);
        end
        LVBL = 1'b1;
        tick();

        for (int i = 0; i < 40; i++) begin
            l0 = ($urandom_range(0, 3) == 0) ? (11'($urandom) | 11'h00F) : pool[$urandom_range(0, 7)];
            l1 = ($urandom_range(0, 2) == 0) ? (11'($urandom) | 11'h00F) : pool[$urandom_range(0, 7)];
            bk = 1'($urandom);
            layer_pxl = {l1, l0};
            pal_bank  = bk;
            expq.push_back(colour(pick_entry(l0, l1), bk));
            pulse();
            if (i > 0) begin
                e = expq.pop_front();
                check($sformatf("rand_px%0d", i), {red, green, blue}, e);
            end
            tick($urandom_range(3, 6));
        end
        expq.delete();

`ifdef JTFRAME_COLMIX_PALGATE_EN
        strobe(11'h042, 1'b0, 1'b0, 8'h5A);
        check("pend_before_reset", pal_wr_pend, 1'b1);
`endif
        layer_pxl = {11'h7FF, 11'h123};
        pal_bank  = 1'b0;
        pulse();
        tick();
        rst_n = 1'b0;
        tick();
        check("midfetch_reset_rgb", {red, green, blue}, 12'h000);
        check("midfetch_reset_pend", pal_wr_pend, 1'b0);
        rst_n = 1'b1;
        tick(6);
        check("post_reset_idle_rgb", {red, green, blue}, 12'h000);
        pulse();
        check("post_reset_staging", {red, green, blue}, 12'h000);
        tick(5);
        pulse();
        check("post_reset_recover", {red, green, blue}, 12'h357);
        LVBL = 1'b0;
        cpu_addr = {11'h042, 1'b0};
        tick(3);
        check("lost_write", pal_dout, 8'h09);

        cpu_wr8(8'h05, 2'd0, 8'h11);
        cpu_wr8(8'h05, 2'd1, 8'h22);
        cpu_wr8(8'h05, 2'd2, 8'h33);
        cpu_wr8(8'h05, 2'd3, 8'h99);
        tick();
        check("c8_sel3_reads0", pal_dout8, 8'h00);
        cpu_addr8 = {8'h05, 2'd1};
        tick();
        check("c8_readback_g", pal_dout8, 8'h22);
        LVBL = 1'b1;
        layer_pxl8 = {8'hFF, 8'h05};
        pal_bank   = 1'b1;
        pulse();
        tick(5);
        pulse();
        check("c8_rgb", {red8, green8, blue8}, 24'h112233);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
